iec_sd_arbiter: RTL and testbench
=================================

Name: iec_sd_arbiter

Overview:
- Shares one host SD block-transfer channel between NDRV drive instances (e.g. drive 8 and drive 9 selectors).
- Sits directly downstream of each drive selector's sd_lba/sd_sz/sd_rd/sd_wr/sd_ack/sd_buff_* interface and upstream of the host SD port.
- Grants one drive at a time, round-robin, and holds the grant for one complete ack-framed transfer.
- Routes ack, write strobe and read-back data only to the granted drive.

Parameters:
- NDRV, 2, number of drive request ports (1..4).

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- drv_sd_lba  in  32*NDRV  per-drive block address; drive i at bits [32i+31:32i].
- drv_sd_sz  in  6*NDRV  per-drive transfer size code; drive i at [6i+5:6i].
- drv_sd_rd  in  NDRV  per-drive read request (level, held until the drive sees its ack).
- drv_sd_wr  in  NDRV  per-drive write request (level).
- drv_sd_buff_din  in  8*NDRV  per-drive write-data byte for the host.
- drv_sd_ack  out  NDRV  ack routed to the granted drive only.
- drv_sd_buff_wr  out  NDRV  host buffer write strobe routed to the granted drive only.
- sd_lba  out  32  latched address of the granted request.
- sd_sz  out  6  latched size of the granted request.
- sd_rd  out  1  host read request.
- sd_wr  out  1  host write request.
- sd_ack  in  1  host acknowledge; high for the duration of a transfer.
- sd_buff_wr  in  1  host buffer write strobe.
- sd_buff_din  out  8  write data from the granted drive.
- grant  out  NDRV  one-hot current owner; 0 when idle.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- States: IDLE, REQ, XFER, REL.
- Reset (asynchronous) forces all of the following, with no partial transfer completed:
  - state=IDLE, rr_ptr=0, grant=0;
  - sd_rd=sd_wr=0, sd_lba=0, sd_sz=0, busy=0.
- IDLE:
  - No new request while sd_ack=1 (stale ack after reset or host glitch).
  - Otherwise scan drives rr_ptr, rr_ptr+1, … mod NDRV. The first drive with rd|wr is granted.
  - On the grant edge latch lba/sz and assert the registered host request, visible next cycle (one-cycle latency).
  - If the drive has rd and wr both high, read wins: sd_rd=1, sd_wr=0. The write is served on a later grant.
  - Go to REQ.
- REQ:
  - Hold sd_rd/sd_wr and sd_lba/sd_sz stable; ignore changes on drive inputs.
  - On sd_ack rising: drop sd_rd/sd_wr in the same registered update and go to XFER.
  - If the granted drive withdraws its request before ack, keep waiting. The host cannot abort.
- XFER:
  - drv_sd_ack[g] = sd_ack and drv_sd_buff_wr[g] = sd_buff_wr for the granted drive g. Both are combinational and carry zero latency.
  - Non-granted drives see 0 on both.
  - On sd_ack falling go to REL.
- REL:
  - drv_sd_ack is 0 for all drives.
  - Wait until drv_sd_rd[g]=0 and drv_sd_wr[g]=0 (minimum one cycle).
  - Then set rr_ptr=(g+1) mod NDRV, clear grant and return to IDLE.
  - Drives are not re-granted from a stale level.
- Ack routing window: drv_sd_ack[g] also follows sd_ack in REQ, so the drive sees the rising edge in the same cycle as the host asserts it.
- sd_buff_din = drv_sd_buff_din slice of g whenever grant≠0, else 8'h00. Purely combinational so the host read path has no added latency.
- Round-robin wrap: rr_ptr counts 0..NDRV-1, then wraps to 0. With NDRV=1 it stays 0.
- Simultaneous requests: only the drive nearest rr_ptr is granted; the others wait with their requests held.
- A transfer (REQ→REL) is never pre-empted.

Decomposition:
- Shared package holds the state enum, IDLE/REQ/XFER/REL encodings and the per-drive slice widths (LBA_W=32, SZ_W=6, DAT_W=8).
- One natural sub-module: iec_sd_rr_pick. It is the combinational round-robin priority encoder (requests, rr_ptr → one-hot pick, valid).

Test Plan:
- Single read: drive0 rd=1, lba=0x00000123, sz=1 → sd_rd=1 one cycle later with sd_lba=0x123 and sd_sz=1. Ack 1 for 512 cycles → drv_sd_ack=2'b01, drive1 sees no buff_wr strobes. Grant cleared after drive0 drops rd.
- Contention: both drives request rd in the same cycle after reset → drive0 served first, then drive1. A third back-to-back pair → drive1 first (rr_ptr=1).
- Write data mux: drive1 wr=1, drv_sd_buff_din[15:8]=0xA5 → sd_wr=1 and sd_buff_din=0xA5 during XFER. sd_buff_din=0x00 after return to IDLE.
- Stale ack: assert reset while sd_ack=1, then release with drive0 rd=1 → sd_rd remains 0 until sd_ack=0, then asserts next cycle.
- Reset mid-transfer: reset pulse in XFER → grant=0, sd_rd=sd_wr=0, drv_sd_ack=0 immediately (asynchronous), state IDLE.
- rd+wr conflict: drive0 rd=wr=1 → sd_rd=1, sd_wr=0. After release and re-request with wr only → sd_wr=1.

Source files
------------

// File: rtl/iec_sd_arbiter_pkg.sv
// Shared types and widths for the IEC drive SD-channel arbiter.
package iec_sd_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2,
        ST_REL  = 2'd3
    } state_e;

    localparam int unsigned LBA_W = 32;
    localparam int unsigned SZ_W  = 6;
    localparam int unsigned DAT_W = 8;

    // Width of a drive index; at least one bit even for a single drive.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/iec_sd_arbiter_if.sv
// Drive-side and host-side SD transfer signals seen by the arbiter.
interface iec_sd_arbiter_if
    import iec_sd_arbiter_pkg::*;
#(
    parameter int unsigned NDRV = 2
);

    logic [LBA_W*NDRV-1:0] drv_sd_lba;
    logic [SZ_W*NDRV-1:0]  drv_sd_sz;
    logic [NDRV-1:0]       drv_sd_rd;
    logic [NDRV-1:0]       drv_sd_wr;
    logic [DAT_W*NDRV-1:0] drv_sd_buff_din;
    logic [NDRV-1:0]       drv_sd_ack;
    logic [NDRV-1:0]       drv_sd_buff_wr;
    logic [LBA_W-1:0]      sd_lba;
    logic [SZ_W-1:0]       sd_sz;
    logic                  sd_rd;
    logic                  sd_wr;
    logic                  sd_ack;
    logic                  sd_buff_wr;
    logic [DAT_W-1:0]      sd_buff_din;
    logic [NDRV-1:0]       grant;
    logic                  busy;

    modport master (
        input  drv_sd_lba, drv_sd_sz, drv_sd_rd, drv_sd_wr, drv_sd_buff_din,
        input  sd_ack, sd_buff_wr,
        output drv_sd_ack, drv_sd_buff_wr, sd_lba, sd_sz, sd_rd, sd_wr,
        output sd_buff_din, grant, busy
    );

    modport slave (
        output drv_sd_lba, drv_sd_sz, drv_sd_rd, drv_sd_wr, drv_sd_buff_din,
        output sd_ack, sd_buff_wr,
        input  drv_sd_ack, drv_sd_buff_wr, sd_lba, sd_sz, sd_rd, sd_wr,
        input  sd_buff_din, grant, busy
    );

endinterface

// File: rtl/iec_sd_rr_pick.sv
// Round-robin priority encoder: first requester at or after ptr_i, wrapping.
module iec_sd_rr_pick
    import iec_sd_arbiter_pkg::*;
#(
    parameter int unsigned NDRV = 2
) (
    input  logic [NDRV-1:0]         req_i,
    input  logic [idx_w(NDRV)-1:0]  ptr_i,
    output logic [NDRV-1:0]         pick_o,
    output logic                    valid_o
);

    localparam int unsigned IW = idx_w(NDRV);

    int unsigned idx;

    always_comb begin
        pick_o  = '0;
        valid_o = 1'b0;
        idx     = 0;
        for (int unsigned i = 0; i < NDRV; i++) begin
            idx = ({{(32-IW){1'b0}}, ptr_i} + i) % NDRV;
            if (!valid_o && req_i[idx[IW-1:0]]) begin
                pick_o[idx[IW-1:0]] = 1'b1;
                valid_o             = 1'b1;
            end
        end
    end

endmodule

// File: rtl/iec_sd_arbiter.sv
// Shares one host SD block-transfer channel between NDRV drives, round-robin,
// holding each grant for one complete ack-framed transfer.
module iec_sd_arbiter
    import iec_sd_arbiter_pkg::*;
#(
    parameter int unsigned NDRV = 2
) (
    input logic              clk_sys,
    input logic              reset,
    iec_sd_arbiter_if.master bus
);

    localparam int unsigned   IW   = idx_w(NDRV);
    localparam logic [IW-1:0] LAST = IW'(NDRV - 1);

    state_e            state_q, state_d;
    logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]     gidx_q, gidx_d;
    logic [NDRV-1:0]   grant_q, grant_d;
    logic              sd_rd_q, sd_rd_d;
    logic              sd_wr_q, sd_wr_d;
    logic [LBA_W-1:0]  lba_q, lba_d;
    logic [SZ_W-1:0]   sz_q, sz_d;

    logic [NDRV-1:0]   req;
    logic [NDRV-1:0]   pick;
    logic              pick_vld;
    logic [IW-1:0]     pick_idx;
    logic              g_req;
    logic [NDRV-1:0]   drv_ack;
    logic [NDRV-1:0]   drv_bwr;
    logic [DAT_W-1:0]  buff_din;

    logic [LBA_W-1:0]  lba_a [NDRV];
    logic [SZ_W-1:0]   sz_a  [NDRV];
    logic [DAT_W-1:0]  din_a [NDRV];

    for (genvar i = 0; i < NDRV; i++) begin : g_unpack
        assign lba_a[i] = bus.drv_sd_lba[i*LBA_W +: LBA_W];
        assign sz_a[i]  = bus.drv_sd_sz[i*SZ_W +: SZ_W];
        assign din_a[i] = bus.drv_sd_buff_din[i*DAT_W +: DAT_W];
    end

    assign req   = bus.drv_sd_rd | bus.drv_sd_wr;
    assign g_req = |(req & grant_q);

    iec_sd_rr_pick #(.NDRV(NDRV)) u_pick (
        .req_i   (req),
        .ptr_i   (rr_ptr_q),
        .pick_o  (pick),
        .valid_o (pick_vld)
    );

    always_comb begin
        pick_idx = '0;
        for (int unsigned j = 0; j < NDRV; j++) begin
            if (pick[j[IW-1:0]]) pick_idx = j[IW-1:0];
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        gidx_d   = gidx_q;
        grant_d  = grant_q;
        sd_rd_d  = sd_rd_q;
        sd_wr_d  = sd_wr_q;
        lba_d    = lba_q;
        sz_d     = sz_q;
        unique case (state_q)
            ST_IDLE: begin
                if (!bus.sd_ack && pick_vld) begin
                    grant_d = pick;
                    gidx_d  = pick_idx;
                    lba_d   = lba_a[pick_idx];
                    sz_d    = sz_a[pick_idx];
                    sd_rd_d = bus.drv_sd_rd[pick_idx];
                    sd_wr_d = bus.drv_sd_wr[pick_idx] & ~bus.drv_sd_rd[pick_idx];
                    state_d = ST_REQ;
                end
            end
            // REQ is only entered with sd_ack low, so a high level here is the rising edge.
            ST_REQ: begin
                if (bus.sd_ack) begin
                    sd_rd_d = 1'b0;
                    sd_wr_d = 1'b0;
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                if (!bus.sd_ack) state_d = ST_REL;
            end
            ST_REL: begin
                if (!g_req) begin
                    rr_ptr_d = (gidx_q == LAST) ? '0 : gidx_q + IW'(1);
                    grant_d  = '0;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            gidx_q   <= '0;
            grant_q  <= '0;
            sd_rd_q  <= 1'b0;
            sd_wr_q  <= 1'b0;
            lba_q    <= '0;
            sz_q     <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            gidx_q   <= gidx_d;
            grant_q  <= grant_d;
            sd_rd_q  <= sd_rd_d;
            sd_wr_q  <= sd_wr_d;
            lba_q    <= lba_d;
            sz_q     <= sz_d;
        end
    end

    // Ack window covers REQ so the drive sees the host's rising edge without delay.
    always_comb begin
        drv_ack  = '0;
        drv_bwr  = '0;
        buff_din = '0;
        if (|grant_q) begin
            buff_din = din_a[gidx_q];
            if (state_q == ST_REQ || state_q == ST_XFER) drv_ack[gidx_q] = bus.sd_ack;
            if (state_q == ST_XFER) drv_bwr[gidx_q] = bus.sd_buff_wr;
        end
    end

    assign bus.drv_sd_ack     = drv_ack;
    assign bus.drv_sd_buff_wr = drv_bwr;
    assign bus.sd_buff_din    = buff_din;
    assign bus.sd_lba         = lba_q;
    assign bus.sd_sz          = sz_q;
    assign bus.sd_rd          = sd_rd_q;
    assign bus.sd_wr          = sd_wr_q;
    assign bus.grant          = grant_q;
    assign bus.busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_iec_sd_arbiter.sv
// Directed self-checking bench for iec_sd_arbiter with two drives.
module tb_iec_sd_arbiter;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    iec_sd_arbiter_if #(.NDRV(2)) bus ();

    iec_sd_arbiter #(.NDRV(2)) dut (
        .clk_sys (clk),
        .reset   (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One ack-framed transfer for the granted drive, then release its request bits.
    task automatic do_xfer(input logic [1:0] m);
        bus.sd_ack = 1'b1;
        tick;
        bus.sd_ack = 1'b0;
        tick;
        bus.drv_sd_rd = bus.drv_sd_rd & ~m;
        bus.drv_sd_wr = bus.drv_sd_wr & ~m;
        tick;
    endtask

    int cnt0;
    int bad1;
    int ackbad;

    initial begin
        checks              = 0;
        failures            = 0;
        rst                 = 1'b1;
        bus.drv_sd_lba      = '0;
        bus.drv_sd_sz       = '0;
        bus.drv_sd_rd       = '0;
        bus.drv_sd_wr       = '0;
        bus.drv_sd_buff_din = '0;
        bus.sd_ack          = 1'b0;
        bus.sd_buff_wr      = 1'b0;
        repeat (2) tick;

        chk("rst_grant", 64'(bus.grant), 64'h0);
        chk("rst_busy", 64'(bus.busy), 64'h0);
        chk("rst_rd", 64'(bus.sd_rd), 64'h0);
        chk("rst_wr", 64'(bus.sd_wr), 64'h0);
        chk("rst_lba", 64'(bus.sd_lba), 64'h0);
        chk("rst_sz", 64'(bus.sd_sz), 64'h0);
        chk("rst_drv_ack", 64'(bus.drv_sd_ack), 64'h0);
        chk("rst_din", 64'(bus.sd_buff_din), 64'h0);
        rst = 1'b0;
        tick;

        // Single read from drive 0
        bus.drv_sd_lba[31:0] = 32'h0000_0123;
        bus.drv_sd_sz[5:0]   = 6'd1;
        bus.drv_sd_rd        = 2'b01;
        #1;
        chk("rd_before_edge", 64'(bus.sd_rd), 64'h0);
        tick;
        chk("rd_req", 64'(bus.sd_rd), 64'h1);
        chk("rd_wr", 64'(bus.sd_wr), 64'h0);
        chk("rd_lba", 64'(bus.sd_lba), 64'h123);
        chk("rd_sz", 64'(bus.sd_sz), 64'h1);
        chk("rd_grant", 64'(bus.grant), 64'h1);
        chk("rd_busy", 64'(bus.busy), 64'h1);
        bus.drv_sd_lba[31:0] = 32'hFFFF_0000;
        bus.drv_sd_sz[5:0]   = 6'd7;
        tick;
        chk("req_lba_hold", 64'(bus.sd_lba), 64'h123);
        chk("req_sz_hold", 64'(bus.sd_sz), 64'h1);
        chk("req_rd_hold", 64'(bus.sd_rd), 64'h1);
        bus.sd_ack = 1'b1;
        #1;
        chk("req_ack_route", 64'(bus.drv_sd_ack), 64'h1);
        tick;
        chk("xfer_rd_drop", 64'(bus.sd_rd), 64'h0);
        cnt0   = 0;
        bad1   = 0;
        ackbad = 0;
        for (int i = 0; i < 512; i++) begin
            bus.sd_buff_wr = 1'(i % 2);
            #1;
            if (bus.drv_sd_buff_wr[0]) cnt0++;
            if (bus.drv_sd_buff_wr[1]) bad1++;
            if (bus.drv_sd_ack !== 2'b01) ackbad++;
            tick;
        end
        bus.sd_buff_wr = 1'b0;
        chk("xfer_strobes_drv0", 64'(cnt0), 64'd256);
        chk("xfer_strobes_drv1", 64'(bad1), 64'd0);
        chk("xfer_ack_pattern", 64'(ackbad), 64'd0);
        bus.sd_ack = 1'b0;
        tick;
        chk("rel_ack_zero", 64'(bus.drv_sd_ack), 64'h0);
        chk("rel_grant_held", 64'(bus.grant), 64'h1);
        tick;
        chk("rel_wait_level", 64'(bus.busy), 64'h1);
        bus.drv_sd_rd = 2'b00;
        tick;
        chk("rel_grant_clear", 64'(bus.grant), 64'h0);
        chk("rel_idle", 64'(bus.busy), 64'h0);

        // Contention after reset: drive 0 first, then drive 1
        rst = 1'b1;
        tick;
        rst = 1'b0;
        bus.drv_sd_lba = {32'h0000_0020, 32'h0000_0010};
        bus.drv_sd_sz  = {6'd2, 6'd3};
        bus.drv_sd_rd  = 2'b11;
        tick;
        chk("cont1_grant", 64'(bus.grant), 64'h1);
        chk("cont1_lba", 64'(bus.sd_lba), 64'h10);
        do_xfer(2'b01);
        chk("cont1_idle_gap", 64'(bus.grant), 64'h0);
        tick;
        chk("cont2_grant", 64'(bus.grant), 64'h2);
        chk("cont2_lba", 64'(bus.sd_lba), 64'h20);
        chk("cont2_sz", 64'(bus.sd_sz), 64'h2);
        do_xfer(2'b10);
        bus.drv_sd_rd = 2'b01;
        tick;
        chk("single0_grant", 64'(bus.grant), 64'h1);
        do_xfer(2'b01);
        bus.drv_sd_rd = 2'b11;
        tick;
        chk("cont3_grant_ptr1", 64'(bus.grant), 64'h2);
        do_xfer(2'b10);
        tick;
        chk("cont3_second", 64'(bus.grant), 64'h1);
        do_xfer(2'b01);

        // Write data mux from drive 1
        rst = 1'b1;
        tick;
        rst = 1'b0;
        bus.drv_sd_buff_din = 16'hA53C;
        bus.drv_sd_wr       = 2'b10;
        tick;
        chk("wr_req", 64'(bus.sd_wr), 64'h1);
        chk("wr_no_rd", 64'(bus.sd_rd), 64'h0);
        chk("wr_grant", 64'(bus.grant), 64'h2);
        bus.sd_ack = 1'b1;
        tick;
        chk("wr_din_xfer", 64'(bus.sd_buff_din), 64'hA5);
        bus.sd_buff_wr = 1'b1;
        #1;
        chk("wr_bwr_route", 64'(bus.drv_sd_buff_wr), 64'h2);
        chk("wr_ack_route", 64'(bus.drv_sd_ack), 64'h2);
        bus.sd_buff_wr = 1'b0;
        bus.sd_ack     = 1'b0;
        tick;
        bus.drv_sd_wr = 2'b00;
        tick;
        chk("wr_din_idle", 64'(bus.sd_buff_din), 64'h0);
        chk("wr_grant_idle", 64'(bus.grant), 64'h0);

        // Stale ack across reset
        bus.sd_ack = 1'b1;
        rst        = 1'b1;
        tick;
        rst           = 1'b0;
        bus.drv_sd_rd = 2'b01;
        tick;
        tick;
        chk("stale_rd", 64'(bus.sd_rd), 64'h0);
        chk("stale_grant", 64'(bus.grant), 64'h0);
        bus.sd_ack = 1'b0;
        #1;
        chk("stale_rd_pre", 64'(bus.sd_rd), 64'h0);
        tick;
        chk("stale_rd_post", 64'(bus.sd_rd), 64'h1);

        // Asynchronous reset in XFER
        bus.sd_ack = 1'b1;
        tick;
        chk("mid_ack_pre", 64'(bus.drv_sd_ack), 64'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_grant", 64'(bus.grant), 64'h0);
        chk("mid_rd", 64'(bus.sd_rd), 64'h0);
        chk("mid_wr", 64'(bus.sd_wr), 64'h0);
        chk("mid_drv_ack", 64'(bus.drv_sd_ack), 64'h0);
        chk("mid_busy", 64'(bus.busy), 64'h0);
        bus.sd_ack    = 1'b0;
        bus.drv_sd_rd = 2'b00;
        tick;
        rst = 1'b0;
        tick;

        // rd+wr conflict: read wins, write served on a later grant
        bus.drv_sd_rd = 2'b01;
        bus.drv_sd_wr = 2'b01;
        tick;
        chk("conf_rd", 64'(bus.sd_rd), 64'h1);
        chk("conf_wr", 64'(bus.sd_wr), 64'h0);
        do_xfer(2'b01);
        bus.drv_sd_wr = 2'b01;
        tick;
        chk("conf_wr2", 64'(bus.sd_wr), 64'h1);
        chk("conf_rd2", 64'(bus.sd_rd), 64'h0);
        do_xfer(2'b01);
        chk("conf_end_grant", 64'(bus.grant), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
